// File: rtl/pipe_control.sv
// Pipeline valid/hold controller: per-stage move enables, branch flush, retire pulse, perf counters.
// Latency: load_en_o is combinational from stall_in/valid; valid_o, redirect_o, retire_o and counters are registered (1 cycle).
// Backpressure: stall_in[i] freezes stage i and ripples back through every occupied stage behind it; a stalled stage emits a bubble forward.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   fetch_en      - new instruction available for stage 0
//   stall_in      - per-stage hold request
//   flush_req     - branch in FLUSH_STAGE is taken
//   valid_o       - per-stage occupancy (registered)
//   load_en_o     - per-stage datapath register enable (combinational)
//   redirect_o    - one-cycle pulse after an accepted flush
//   retire_o      - one-cycle pulse after the last stage hands off its instruction
//   *_cnt_o       - saturating stall / flush / retire counters
module pipe_control #(
  parameter int STAGES      = 5,
  parameter int FLUSH_STAGE = 2,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [STAGES-1:0] stall_in,
  input  logic              flush_req,
  output logic [STAGES-1:0] valid_o,
  output logic [STAGES-1:0] load_en_o,
  output logic              redirect_o,
  output logic              retire_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  retire_cnt_o
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] vld_eff;
  logic [STAGES-1:0] move;
  logic [STAGES-1:0] pass;
  logic              flush_acc;
  logic              retire_ev;
  logic              stall_ev;
  logic              redirect_q, retire_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic ev);
    if (ev && !(&c)) begin
      return c + CNT_W'(1);
    end
    return c;
  endfunction

  // While reset is held the pipe is treated as empty, so load enables
  // reduce to the inverted stall vector and no flush/retire can be seen.
  assign vld_eff = rst ? '0 : valid_q;
  assign pass    = vld_eff & ~stall_in;

  // Move ripples from writeback back toward fetch: an occupied stage may
  // only advance if the stage ahead of it is also advancing.
  always_comb begin
    logic ripple;
    ripple = 1'b0;
    move   = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      if (i == STAGES-1) begin
        ripple = ~stall_in[i];
      end else begin
        ripple = ~stall_in[i] & (~vld_eff[i] | ripple);
      end
      move[i] = ripple;
    end
  end

  assign load_en_o = move;

  // The branch itself must be able to step forward for the flush to take;
  // otherwise the request is dropped and retried by the producer.
  assign flush_acc = flush_req & vld_eff[FLUSH_STAGE] & ~stall_in[FLUSH_STAGE]
                   & move[FLUSH_STAGE+1];
  assign retire_ev = vld_eff[STAGES-1] & ~stall_in[STAGES-1];
  assign stall_ev  = |(vld_eff & stall_in);

  always_comb begin
    valid_d = valid_q;
    if (move[0]) begin
      valid_d[0] = fetch_en;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (move[i]) begin
        valid_d[i] = pass[i-1];
      end
    end
    // Flush kills the branch's own slot and everything younger; the branch
    // has already been copied into FLUSH_STAGE+1 above.
    if (flush_acc) begin
      for (int j = 0; j <= FLUSH_STAGE; j++) begin
        valid_d[j] = 1'b0;
      end
    end
  end

  always_comb begin
    stall_cnt_d  = sat_inc(stall_cnt_q, stall_ev);
    flush_cnt_d  = sat_inc(flush_cnt_q, flush_acc);
    retire_cnt_d = sat_inc(retire_cnt_q, retire_ev);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      redirect_q   <= 1'b0;
      retire_q     <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      redirect_q   <= flush_acc;
      retire_q     <= retire_ev;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign redirect_o   = redirect_q;
  assign retire_o     = retire_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
  assign retire_cnt_o = retire_cnt_q;

endmodule
